// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the DataMEM access arbiter.
//   - loadStoreWidth codes understood by DataMEM
//   - arbiter FSM state encoding
//   - requester (owner) identifiers
package dmem_arb_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_RSVD = 2'b10;
    localparam logic [1:0] W_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_align_check.sv
// Combinational access-legality check.
// Ports:
//   width   in  2  requested loadStoreWidth code
//   addr_lo in  2  low two bits of the byte address
//   err     out 1  1 = reserved width or address not naturally aligned
module dmem_align_check
    import dmem_arb_pkg::*;
(
    input  logic [1:0] width,
    input  logic [1:0] addr_lo,
    output logic       err
);

    // Flag accesses DataMEM cannot perform as one naturally aligned beat
    always_comb begin
        err = 1'b0;
        case (width)
            W_BYTE:  err = 1'b0;
            W_HALF:  err = addr_lo[0];
            W_WORD:  err = (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Arbiter sharing the single-port DataMEM between the CPU load/store port
// (cpu_*) and the debug/loader port (dbg_*). One request is latched at a time,
// played onto the DataMEM control lines for one cycle, and answered through a
// valid/ready response handshake. Illegal accesses never reach memory.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   -> round-robin between simultaneous requests
//   undefined -> fixed priority, CPU wins every tie
//
// Ports:
//   CLK, Reset                   clock, asynchronous active-high reset
//   {cpu,dbg}_req_valid/ready    request handshake (ready is combinational)
//   {cpu,dbg}_req_write/addr/wdata/width/sign   request fields
//   {cpu,dbg}_rsp_valid/ready    response handshake
//   {cpu,dbg}_rsp_rdata/err      response payload
//   mem_MemToReg, mem_MemWrite   DataMEM read select / write strobe
//   mem_width, mem_sign          DataMEM loadStoreWidth / loadSign
//   mem_addr, mem_wdata          DataMEM memAddr / writeData
//   mem_rdata                    DataMEM writeBackData (combinational)
module dmem_access_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          Reset,

    input  logic          cpu_req_valid,
    output logic          cpu_req_ready,
    input  logic          cpu_req_write,
    input  logic [AW-1:0] cpu_req_addr,
    input  logic [DW-1:0] cpu_req_wdata,
    input  logic [1:0]    cpu_req_width,
    input  logic          cpu_req_sign,
    output logic          cpu_rsp_valid,
    input  logic          cpu_rsp_ready,
    output logic [DW-1:0] cpu_rsp_rdata,
    output logic          cpu_rsp_err,

    input  logic          dbg_req_valid,
    output logic          dbg_req_ready,
    input  logic          dbg_req_write,
    input  logic [AW-1:0] dbg_req_addr,
    input  logic [DW-1:0] dbg_req_wdata,
    input  logic [1:0]    dbg_req_width,
    input  logic          dbg_req_sign,
    output logic          dbg_rsp_valid,
    input  logic          dbg_rsp_ready,
    output logic [DW-1:0] dbg_rsp_rdata,
    output logic          dbg_rsp_err,

    output logic          mem_MemToReg,
    output logic          mem_MemWrite,
    output logic [1:0]    mem_width,
    output logic          mem_sign,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_r;
    state_t        state_nxt_s;
    owner_t        owner_r;
    logic          err_r;

    logic          grant_cpu_s;
    logic          grant_dbg_s;
    logic          accept_s;
    owner_t        sel_owner_s;
    logic          sel_write_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic [1:0]    sel_width_s;
    logic          sel_sign_s;
    logic          sel_err_s;
    logic          owner_rsp_ready_s;
    logic [DW-1:0] rdata_cap_s;

    // DataMEM drive registers; they carry the latched request and are
    // non-zero only while the FSM sits in ACCESS.
    logic          mem_read_r;
    logic          mem_write_r;
    logic [1:0]    mem_width_r;
    logic          mem_sign_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;

    logic          cpu_rsp_valid_r;
    logic [DW-1:0] cpu_rsp_rdata_r;
    logic          cpu_rsp_err_r;
    logic          dbg_rsp_valid_r;
    logic [DW-1:0] dbg_rsp_rdata_r;
    logic          dbg_rsp_err_r;

`ifdef DMEM_ARB_RR_EN
    owner_t        rr_last_r;
`endif

    // Arbitration: grants are only offered while idle
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dbg_s = 1'b0;
        if (state_r == IDLE) begin
            if (cpu_req_valid && dbg_req_valid) begin
`ifdef DMEM_ARB_RR_EN
                // Whoever was not served last wins the tie
                if (rr_last_r == OWN_CPU) begin
                    grant_dbg_s = 1'b1;
                end else begin
                    grant_cpu_s = 1'b1;
                end
`else
                grant_cpu_s = 1'b1;
`endif
            end else if (cpu_req_valid) begin
                grant_cpu_s = 1'b1;
            end else if (dbg_req_valid) begin
                grant_dbg_s = 1'b1;
            end else begin
                grant_cpu_s = 1'b0;
                grant_dbg_s = 1'b0;
            end
        end else begin
            grant_cpu_s = 1'b0;
            grant_dbg_s = 1'b0;
        end
    end

    // Ready is suppressed while reset is asserted so nothing looks accepted
    assign cpu_req_ready = grant_cpu_s & ~Reset;
    assign dbg_req_ready = grant_dbg_s & ~Reset;
    assign accept_s      = grant_cpu_s | grant_dbg_s;

    assign sel_owner_s = grant_dbg_s ? OWN_DBG       : OWN_CPU;
    assign sel_write_s = grant_dbg_s ? dbg_req_write : cpu_req_write;
    assign sel_addr_s  = grant_dbg_s ? dbg_req_addr  : cpu_req_addr;
    assign sel_wdata_s = grant_dbg_s ? dbg_req_wdata : cpu_req_wdata;
    assign sel_width_s = grant_dbg_s ? dbg_req_width : cpu_req_width;
    assign sel_sign_s  = grant_dbg_s ? dbg_req_sign  : cpu_req_sign;

    dmem_align_check u_align_check (
        .width   (sel_width_s),
        .addr_lo (sel_addr_s[1:0]),
        .err     (sel_err_s)
    );

    assign owner_rsp_ready_s = (owner_r == OWN_DBG) ? dbg_rsp_ready : cpu_rsp_ready;

    // Read data is only taken from memory for a legal load
    assign rdata_cap_s = mem_read_r ? mem_rdata : {DW{1'b0}};

    // FSM state register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: state_nxt_s = RESP;
            RESP: begin
                if (owner_rsp_ready_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request latch, DataMEM drive and response capture
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            owner_r         <= OWN_CPU;
            err_r           <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_width_r     <= 2'b00;
            mem_sign_r      <= 1'b0;
            mem_addr_r      <= {AW{1'b0}};
            mem_wdata_r     <= {DW{1'b0}};
            cpu_rsp_valid_r <= 1'b0;
            cpu_rsp_rdata_r <= {DW{1'b0}};
            cpu_rsp_err_r   <= 1'b0;
            dbg_rsp_valid_r <= 1'b0;
            dbg_rsp_rdata_r <= {DW{1'b0}};
            dbg_rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r     <= sel_owner_s;
                        err_r       <= sel_err_s;
                        mem_read_r  <= ~sel_write_s & ~sel_err_s;
                        mem_write_r <= sel_write_s & ~sel_err_s;
                        mem_width_r <= sel_width_s;
                        mem_sign_r  <= sel_sign_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                    end else begin
                        owner_r     <= owner_r;
                        err_r       <= err_r;
                    end
                end
                ACCESS: begin
                    // Single memory cycle: drop the bus and post the response
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                    mem_width_r <= 2'b00;
                    mem_sign_r  <= 1'b0;
                    mem_addr_r  <= {AW{1'b0}};
                    mem_wdata_r <= {DW{1'b0}};
                    if (owner_r == OWN_DBG) begin
                        dbg_rsp_valid_r <= 1'b1;
                        dbg_rsp_rdata_r <= rdata_cap_s;
                        dbg_rsp_err_r   <= err_r;
                    end else begin
                        cpu_rsp_valid_r <= 1'b1;
                        cpu_rsp_rdata_r <= rdata_cap_s;
                        cpu_rsp_err_r   <= err_r;
                    end
                end
                RESP: begin
                    if (owner_rsp_ready_s) begin
                        cpu_rsp_valid_r <= 1'b0;
                        cpu_rsp_rdata_r <= {DW{1'b0}};
                        cpu_rsp_err_r   <= 1'b0;
                        dbg_rsp_valid_r <= 1'b0;
                        dbg_rsp_rdata_r <= {DW{1'b0}};
                        dbg_rsp_err_r   <= 1'b0;
                    end else begin
                        cpu_rsp_valid_r <= cpu_rsp_valid_r;
                        dbg_rsp_valid_r <= dbg_rsp_valid_r;
                    end
                end
                default: begin
                    mem_read_r      <= 1'b0;
                    mem_write_r     <= 1'b0;
                    cpu_rsp_valid_r <= 1'b0;
                    dbg_rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember the most recently granted owner; reset favours the CPU
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rr_last_r <= OWN_DBG;
        end else if (accept_s) begin
            rr_last_r <= sel_owner_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end
`endif

    assign mem_MemToReg  = mem_read_r;
    assign mem_MemWrite  = mem_write_r;
    assign mem_width     = mem_width_r;
    assign mem_sign      = mem_sign_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;

    assign cpu_rsp_valid = cpu_rsp_valid_r;
    assign cpu_rsp_rdata = cpu_rsp_rdata_r;
    assign cpu_rsp_err   = cpu_rsp_err_r;
    assign dbg_rsp_valid = dbg_rsp_valid_r;
    assign dbg_rsp_rdata = dbg_rsp_rdata_r;
    assign dbg_rsp_err   = dbg_rsp_err_r;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter: directed scenarios followed by
// randomized traffic from both requesters, checked against a byte-level
// reference memory and a simple grant-order model.
module tb_dmem_access_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          Reset;
    logic          cpu_req_valid, cpu_req_ready, cpu_req_write, cpu_req_sign;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_wdata;
    logic [1:0]    cpu_req_width;
    logic          cpu_rsp_valid, cpu_rsp_ready, cpu_rsp_err;
    logic [DW-1:0] cpu_rsp_rdata;
    logic          dbg_req_valid, dbg_req_ready, dbg_req_write, dbg_req_sign;
    logic [AW-1:0] dbg_req_addr;
    logic [DW-1:0] dbg_req_wdata;
    logic [1:0]    dbg_req_width;
    logic          dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_err;
    logic [DW-1:0] dbg_rsp_rdata;
    logic          mem_MemToReg, mem_MemWrite, mem_sign;
    logic [1:0]    mem_width;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic        sign;
    } req_t;

    req_t        cpu_q, dbg_q;
    bit          cpu_pend, dbg_pend;
    bit          last_dbg;
    logic [31:0] last_rdata;
    logic        last_err;
    int          total, bad;

    logic [7:0]  dmem    [0:63];
    logic [7:0]  ref_mem [0:63];
    logic [5:0]  dm_idx;

    always #5 CLK = ~CLK;

    dmem_access_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_req_width(cpu_req_width),
        .cpu_req_sign(cpu_req_sign), .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_ready(cpu_rsp_ready), .cpu_rsp_rdata(cpu_rsp_rdata),
        .cpu_rsp_err(cpu_rsp_err),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_req_width(dbg_req_width),
        .dbg_req_sign(dbg_req_sign), .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_rdata(dbg_rsp_rdata),
        .dbg_rsp_err(dbg_rsp_err),
        .mem_MemToReg(mem_MemToReg), .mem_MemWrite(mem_MemWrite),
        .mem_width(mem_width), .mem_sign(mem_sign),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // DataMEM stand-in: 64-byte little-endian memory, combinational read
    always_comb begin
        dm_idx    = mem_addr[5:0];
        mem_rdata = 32'h0;
        if (mem_MemToReg) begin
            case (mem_width)
                2'b00: mem_rdata = mem_sign ? {{24{dmem[dm_idx][7]}}, dmem[dm_idx]}
                                            : {24'h0, dmem[dm_idx]};
                2'b01: mem_rdata = mem_sign ? {{16{dmem[dm_idx + 6'd1][7]}}, dmem[dm_idx + 6'd1], dmem[dm_idx]}
                                            : {16'h0, dmem[dm_idx + 6'd1], dmem[dm_idx]};
                2'b11: mem_rdata = {dmem[dm_idx + 6'd3], dmem[dm_idx + 6'd2],
                                    dmem[dm_idx + 6'd1], dmem[dm_idx]};
                default: mem_rdata = 32'h0;
            endcase
        end
    end

    // DataMEM stand-in write port
    always @(posedge CLK) begin
        if (mem_MemWrite) begin
            dmem[dm_idx] <= mem_wdata[7:0];
            if (mem_width != 2'b00) dmem[dm_idx + 6'd1] <= mem_wdata[15:8];
            if (mem_width == 2'b11) begin
                dmem[dm_idx + 6'd2] <= mem_wdata[23:16];
                dmem[dm_idx + 6'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_err(input req_t r);
        if (r.width == 2'b10) return 1'b1;
        return (r.addr % nbytes(r.width)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input req_t r);
        int a, v;
        a = int'(r.addr[5:0]);
        v = 0;
        for (int i = nbytes(r.width) - 1; i >= 0; i--) v = v * 256 + int'(ref_mem[(a + i) % 64]);
        if (r.sign && r.width == 2'b00 && v >= 128)   v -= 256;
        if (r.sign && r.width == 2'b01 && v >= 32768) v -= 65536;
        return 32'(v);
    endfunction

    task automatic ref_store(input req_t r);
        int a;
        a = int'(r.addr[5:0]);
        for (int i = 0; i < nbytes(r.width); i++)
            ref_mem[(a + i) % 64] = 8'((r.wdata >> (8 * i)) & 32'hFF);
    endtask

    task automatic drive_reqs();
        cpu_req_valid = cpu_pend;  cpu_req_write = cpu_q.write; cpu_req_addr = cpu_q.addr;
        cpu_req_wdata = cpu_q.wdata; cpu_req_width = cpu_q.width; cpu_req_sign = cpu_q.sign;
        dbg_req_valid = dbg_pend;  dbg_req_write = dbg_q.write; dbg_req_addr = dbg_q.addr;
        dbg_req_wdata = dbg_q.wdata; dbg_req_width = dbg_q.width; dbg_req_sign = dbg_q.sign;
    endtask

    function automatic req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] wd, input logic s);
        req_t r;
        r.write = w; r.addr = a; r.wdata = d; r.width = wd; r.sign = s;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endfunction

    // One arbitration round; entered and left on a falling edge while idle
    task automatic serve_one(input int delay);
        bit          win_dbg, exp_err;
        req_t        cur;
        logic [31:0] exp_rd;
        drive_reqs();
        #1;
        if (!cpu_pend && !dbg_pend) begin
            check("idle_cpu_ready", 32'(cpu_req_ready), 32'h0);
            check("idle_dbg_ready", 32'(dbg_req_ready), 32'h0);
            @(negedge CLK);
        end else begin
            win_dbg = dbg_pend && (!cpu_pend || (RR_MODE && !last_dbg));
            check("grant_cpu_ready", 32'(cpu_req_ready), 32'(!win_dbg));
            check("grant_dbg_ready", 32'(dbg_req_ready), 32'(win_dbg));
            cur      = win_dbg ? dbg_q : cpu_q;
            last_dbg = win_dbg;
            exp_err  = ref_err(cur);
            exp_rd   = 32'h0;
            if (!exp_err && !cur.write) exp_rd = ref_load(cur);
            if (!exp_err && cur.write)  ref_store(cur);

            @(negedge CLK);
            if (win_dbg) dbg_pend = 1'b0; else cpu_pend = 1'b0;
            drive_reqs();
            #1;
            check("acc_memwrite", 32'(mem_MemWrite), 32'(cur.write && !exp_err));
            check("acc_memtoreg", 32'(mem_MemToReg), 32'(!cur.write && !exp_err));
            if (!exp_err) begin
                check("acc_addr",  mem_addr, cur.addr);
                check("acc_width", 32'(mem_width), 32'(cur.width));
                if (cur.write) check("acc_wdata", mem_wdata, cur.wdata);
                else           check("acc_sign", 32'(mem_sign), 32'(cur.sign));
            end
            check("acc_rsp_valid", 32'({cpu_rsp_valid, dbg_rsp_valid}), 32'h0);
            check("acc_ready", 32'({cpu_req_ready, dbg_req_ready}), 32'h0);

            for (int k = 0; k <= delay; k++) begin
                @(negedge CLK);
                if (k == delay) begin
                    if (win_dbg) dbg_rsp_ready = 1'b1; else cpu_rsp_ready = 1'b1;
                end
                #1;
                last_rdata = win_dbg ? dbg_rsp_rdata : cpu_rsp_rdata;
                last_err   = win_dbg ? dbg_rsp_err   : cpu_rsp_err;
                check("rsp_owner_valid", 32'(win_dbg ? dbg_rsp_valid : cpu_rsp_valid), 32'h1);
                check("rsp_other_valid", 32'(win_dbg ? cpu_rsp_valid : dbg_rsp_valid), 32'h0);
                check("rsp_rdata", last_rdata, exp_rd);
                check("rsp_err", 32'(last_err), 32'(exp_err));
                check("rsp_strobes", 32'({mem_MemWrite, mem_MemToReg}), 32'h0);
                check("rsp_no_grant", 32'({cpu_req_ready, dbg_req_ready}), 32'h0);
            end
            @(negedge CLK);
            cpu_rsp_ready = 1'b0;
            dbg_rsp_ready = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] b;
        total = 0; bad = 0;
        cpu_pend = 1'b0; dbg_pend = 1'b0; last_dbg = 1'b1;
        cpu_q = mk(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        dbg_q = cpu_q;
        cpu_rsp_ready = 1'b0; dbg_rsp_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            dmem[i] = b;
            ref_mem[i] = b;
        end
        Reset = 1'b1;
        cpu_pend = 1'b1;
        drive_reqs();
        #1;
        check("rst_cpu_ready", 32'(cpu_req_ready), 32'h0);
        check("rst_strobes", 32'({mem_MemWrite, mem_MemToReg}), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rsp_valid", 32'({cpu_rsp_valid, dbg_rsp_valid}), 32'h0);
        cpu_pend = 1'b0;
        drive_reqs();
        repeat (2) @(negedge CLK);
        Reset = 1'b0;

        // Word store then load
        cpu_q = mk(1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0); cpu_pend = 1'b1; serve_one(0);
        cpu_q = mk(1'b0, 32'h10, 32'h0, 2'b11, 1'b0);        cpu_pend = 1'b1; serve_one(0);
        check("t1_word_load", last_rdata, 32'hDEADBEEF);

        // Byte store, signed and unsigned reload
        cpu_q = mk(1'b1, 32'h13, 32'h000000A1, 2'b00, 1'b0); cpu_pend = 1'b1; serve_one(1);
        cpu_q = mk(1'b0, 32'h13, 32'h0, 2'b00, 1'b1);        cpu_pend = 1'b1; serve_one(0);
        check("t2_byte_signed", last_rdata, 32'hFFFFFFA1);
        cpu_q = mk(1'b0, 32'h13, 32'h0, 2'b00, 1'b0);        cpu_pend = 1'b1; serve_one(0);
        check("t2_byte_unsigned", last_rdata, 32'h000000A1);

        // Trapped accesses
        cpu_q = mk(1'b0, 32'h11, 32'h0, 2'b01, 1'b0);        cpu_pend = 1'b1; serve_one(0);
        check("t3_half_mis_err", 32'(last_err), 32'h1);
        cpu_q = mk(1'b1, 32'h10, 32'h55AA55AA, 2'b10, 1'b0); cpu_pend = 1'b1; serve_one(0);
        check("t3_rsvd_err", 32'(last_err), 32'h1);
        check("t3_rsvd_rdata", last_rdata, 32'h0);

        // Simultaneous requests, repeated
        for (int r = 0; r < 3; r++) begin
            cpu_q = rand_req(); dbg_q = rand_req();
            cpu_pend = 1'b1; dbg_pend = 1'b1;
            serve_one(0);
            serve_one(0);
        end

        // Stalled response with a competing request waiting
        cpu_q = mk(1'b0, 32'h10, 32'h0, 2'b11, 1'b0); cpu_pend = 1'b1;
        dbg_q = mk(1'b0, 32'h12, 32'h0, 2'b01, 1'b1); dbg_pend = 1'b1;
        serve_one(5);
        serve_one(0);

        // Reset in the middle of a CPU store
        cpu_q = mk(1'b1, 32'h20, 32'h12345678, 2'b11, 1'b0); cpu_pend = 1'b1;
        drive_reqs();
        #1;
        check("t6_accept", 32'(cpu_req_ready), 32'h1);
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        cpu_pend = 1'b0;
        drive_reqs();
        #1;
        check("t6_rst_strobes", 32'({mem_MemWrite, mem_MemToReg}), 32'h0);
        check("t6_rst_addr", mem_addr, 32'h0);
        check("t6_rst_rsp", 32'({cpu_rsp_valid, dbg_rsp_valid}), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        last_dbg = 1'b1;
        for (int i = 32; i < 36; i++) check("t6_no_write", 32'(dmem[i]), 32'(ref_mem[i]));
        cpu_q = mk(1'b0, 32'h20, 32'h0, 2'b11, 1'b0); cpu_pend = 1'b1;
        dbg_q = mk(1'b0, 32'h24, 32'h0, 2'b11, 1'b0); dbg_pend = 1'b1;
        serve_one(0);
        serve_one(0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            if (!cpu_pend && $urandom_range(0, 1) == 1) begin cpu_q = rand_req(); cpu_pend = 1'b1; end
            if (!dbg_pend && $urandom_range(0, 1) == 1) begin dbg_q = rand_req(); dbg_pend = 1'b1; end
            serve_one($urandom_range(0, 3));
        end
        serve_one(0);
        serve_one(0);

        for (int i = 0; i < 64; i++) check("final_mem", 32'(dmem[i]), 32'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
